// File: rtl/aont_inverse.sv
// aont_inverse
// Receive-side inverse of the latin-square all-or-nothing transform.
// Recovers a msglen-bit plaintext from a transformed message using the
// same key and keyed latin square as the forward transform.
//
// Ports:
//   clk          sole clock, rising edge
//   rstn         asynchronous active-low reset
//   start        request, sampled only while idle
//   msgIn        transformed message, captured on the accepted start
//   k            key, symbol j at bits [4j+3:4j], captured on start
//   latinsquare  L[r][c] at bits [(lslen*r+c)*lslenlog +: lslenlog],
//                must be held stable while busy
//   msgOut       recovered plaintext, updated only on completion
//   busy         high from the cycle after the accepted start to completion
//   done         one-cycle pulse when msgOut holds a new result
//   err          sticky column-search failure flag, cleared on next start
//
// Handshake: a request is accepted on any rising edge where start=1 and
// the block is idle (busy=0); start is ignored otherwise. Exactly one done
// pulse follows each accepted request unless reset intervenes. start may be
// high in the done cycle and is accepted on that edge.
module aont_inverse #(
  parameter int msglen     = 512,
  parameter int noofblocks = 8,
  parameter int lslen      = 16,
  parameter int lslenlog   = 4
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               start,
  input  logic [msglen-1:0]                  msgIn,
  input  logic [lslen*lslenlog-1:0]          k,
  input  logic [lslen*lslen*lslenlog-1:0]    latinsquare,
  output logic [msglen-1:0]                  msgOut,
  output logic                               busy,
  output logic                               done,
  output logic                               err
);

  // msglen = lslen*lslenlog*noofblocks, so the symbol count is lslen*noofblocks.
  localparam int NSYM = lslen * noofblocks;
  localparam int JW   = $clog2(lslen);
  localparam int TW   = $clog2(NSYM);
  localparam int KW   = lslen * lslenlog;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SEED   = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;

  logic [1:0]          state_q,  state_d;
  logic [msglen-1:0]   msg_q,    msg_d;
  logic [KW-1:0]       key_q,    key_d;
  logic [msglen-1:0]   res_q,    res_d;
  logic [msglen-1:0]   msgout_q, msgout_d;
  logic [lslenlog-1:0] leader_q, leader_d;
  logic [lslenlog-1:0] prev_q,   prev_d;
  logic [JW-1:0]       j_q,      j_d;
  logic [TW-1:0]       t_q,      t_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic                err_q,    err_d;

  // Lookup/search results
  logic [lslenlog-1:0] key_sym;
  logic [lslenlog-1:0] chain_step;
  logic [lslenlog-1:0] c_cur;
  logic [lslenlog-1:0] m_cur;
  logic                m_found;

  always_comb begin
    key_sym    = key_q[int'(j_q)*lslenlog +: lslenlog];
    chain_step = latinsquare[(int'(key_sym)*lslen + int'(leader_q))*lslenlog +: lslenlog];
    c_cur      = msg_q[int'(t_q)*lslenlog +: lslenlog];

    // 16-way compare along row prev; scanning downward leaves the lowest
    // matching column as the result when the square is not latin.
    m_cur   = '0;
    m_found = 1'b0;
    for (int x = lslen - 1; x >= 0; x--) begin
      if (latinsquare[(int'(prev_q)*lslen + x)*lslenlog +: lslenlog] == c_cur) begin
        m_cur   = lslenlog'(x);
        m_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    key_d    = key_q;
    res_d    = res_q;
    msgout_d = msgout_q;
    leader_d = leader_q;
    prev_d   = prev_q;
    j_d      = j_q;
    t_d      = t_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          msg_d    = msgIn;
          key_d    = k;
          res_d    = '0;
          leader_d = {{(lslenlog-1){1'b0}}, k[0]};
          err_d    = 1'b0;
          j_d      = JW'(1);
          busy_d   = 1'b1;
          state_d  = S_SEED;
        end
      end
      S_SEED: begin
        leader_d = chain_step;
        j_d      = j_q + JW'(1);
        if (j_q == JW'(lslen - 1)) begin
          // chain_step is leader[lslen-1], i.e. the seed c(-1).
          prev_d  = chain_step;
          t_d     = '0;
          j_d     = '0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        res_d[int'(t_q)*lslenlog +: lslenlog] = m_cur;
        prev_d = c_cur;
        if (!m_found) begin
          err_d = 1'b1;
        end
        t_d = t_q + TW'(1);
        if (t_q == TW'(NSYM - 1)) begin
          msgout_d = res_d;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          t_d      = '0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      msg_q    <= '0;
      key_q    <= '0;
      res_q    <= '0;
      msgout_q <= '0;
      leader_q <= '0;
      prev_q   <= '0;
      j_q      <= '0;
      t_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      key_q    <= key_d;
      res_q    <= res_d;
      msgout_q <= msgout_d;
      leader_q <= leader_d;
      prev_q   <= prev_d;
      j_q      <= j_d;
      t_q      <= t_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign msgOut = msgout_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_aont_inverse.sv
// Testbench for aont_inverse: directed scenarios plus randomised
// plaintext/key/latin-square round trips through a forward-transform model.
module tb_aont_inverse;

  localparam int MSGLEN = 512;
  localparam int NSYM   = 128;
  localparam int LAT    = 143;
  localparam int W      = MSGLEN + 1;  // {err, msgOut}

  logic               clk;
  logic               rstn;
  logic               start;
  logic [MSGLEN-1:0]  msg_in;
  logic [63:0]        key;
  logic [1023:0]      ls;
  logic [MSGLEN-1:0]  msg_out;
  logic               busy;
  logic               done;
  logic               err;

  logic [W-1:0] exp_q[$];
  int errors;
  int checks;

  aont_inverse dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .msgIn       (msg_in),
    .k           (key),
    .latinsquare (ls),
    .msgOut      (msg_out),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // ---------------- latin squares / model ----------------
  task automatic set_ls_add();
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        ls[(16*r+c)*4 +: 4] = 4'((r + c) % 16);
  endtask

  task automatic set_ls_sbox();
    logic [3:0] sb [16];
    logic [3:0] tmp;
    int j;
    for (int i = 0; i < 16; i++) sb[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = sb[i]; sb[i] = sb[j]; sb[j] = tmp;
    end
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        ls[(16*r+c)*4 +: 4] = sb[(r + c) % 16];
  endtask

  function automatic logic [3:0] lget(input logic [3:0] r, input logic [3:0] c);
    return ls[(16*int'(r)+int'(c))*4 +: 4];
  endfunction

  // Forward transform: seed chain then c(t) = L[x(t-1)][m(t)].
  function automatic logic [MSGLEN-1:0] fwd(input logic [MSGLEN-1:0] pt, input logic [63:0] kk);
    logic [3:0] x;
    logic [MSGLEN-1:0] ct;
    x = {3'b0, kk[0]};
    for (int j = 1; j < 16; j++) x = lget(kk[4*j +: 4], x);
    ct = '0;
    for (int t = 0; t < NSYM; t++) begin
      x = lget(x, pt[4*t +: 4]);
      ct[4*t +: 4] = x;
    end
    return ct;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [MSGLEN-1:0] m, input logic [63:0] kk, input bit expect_err,
                       input logic [MSGLEN-1:0] exp_pt);
    start  = 1'b1;
    msg_in = m;
    key    = kk;
    exp_q.push_back({expect_err, exp_pt});
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1'b1;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags busy=%b done=%b err=%b required 000", busy, done, err);
    end
    checks++;
    if (msg_out !== '0) begin
      errors++;
      $display("FAIL reset_msgout got %h required 0", msg_out);
    end
  endtask

  task automatic test_zero();
    int n; bit seen; logic [W-1:0] e;
    set_ls_add();
    issue('0, '0, 1'b0, '0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_busy got %b required 1", busy);
    end
    wait_done(300, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || n != LAT) begin
      errors++;
      $display("FAIL zero_latency got %0d (seen=%0b) required %0d", n, seen, LAT);
    end
    checks++;
    if (msg_out !== e[MSGLEN-1:0] || err !== e[MSGLEN] || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_result got %h err=%b busy=%b required %h err=%b", msg_out, err, busy,
               e[MSGLEN-1:0], e[MSGLEN]);
    end
    tick(1);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_done_pulse got %b required 0", done);
    end
  endtask

  task automatic test_ramp();
    int n; bit seen; logic [W-1:0] e;
    logic [MSGLEN-1:0] m, x;
    for (int t = 0; t < NSYM; t++) m[4*t +: 4] = 4'(t % 16);
    x = '0;
    for (int t = 1; t < NSYM; t++) x[4*t +: 4] = 4'h1;
    issue(m, '0, 1'b0, x);
    wait_done(300, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || msg_out !== e[MSGLEN-1:0] || err !== e[MSGLEN]) begin
      errors++;
      $display("FAIL ramp_result got %h err=%b (seen=%0b) required %h err=%b", msg_out, err, seen,
               e[MSGLEN-1:0], e[MSGLEN]);
    end
  endtask

  task automatic test_key2();
    int n; bit seen; logic [W-1:0] e;
    logic [MSGLEN-1:0] m;
    logic [63:0] kk;
    kk = {16{4'h2}};
    m = {NSYM{4'hE}};
    issue(m, kk, 1'b0, '0);
    wait_done(300, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || msg_out !== e[MSGLEN-1:0] || err !== e[MSGLEN]) begin
      errors++;
      $display("FAIL key2_allE got %h err=%b required %h err=%b", msg_out, err, e[MSGLEN-1:0], e[MSGLEN]);
    end
    m = '0;
    m[3:0] = 4'h2;
    issue('0, kk, 1'b0, m);
    wait_done(300, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || msg_out !== e[MSGLEN-1:0] || err !== e[MSGLEN]) begin
      errors++;
      $display("FAIL key2_zero got %h err=%b required %h err=%b", msg_out, err, e[MSGLEN-1:0], e[MSGLEN]);
    end
  endtask

  task automatic test_err();
    int n; bit seen; logic [W-1:0] e;
    logic [MSGLEN-1:0] m, x;
    set_ls_add();
    for (int c = 0; c < 16; c++) ls[c*4 +: 4] = 4'h0;
    m = '0;
    m[3:0] = 4'h5;
    // m(0): row 0 has no 5 -> 0, err; m(1): L[5][x]=0 -> 11; rest 0.
    x = '0;
    x[7:4] = 4'hB;
    issue(m, '0, 1'b1, x);
    wait_done(300, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || err !== e[MSGLEN]) begin
      errors++;
      $display("FAIL err_flag got %b (seen=%0b) required %b", err, seen, e[MSGLEN]);
    end
    checks++;
    if (msg_out !== e[MSGLEN-1:0]) begin
      errors++;
      $display("FAIL err_result got %h required %h", msg_out, e[MSGLEN-1:0]);
    end
    set_ls_add();
    issue('0, '0, 1'b0, '0);
    wait_done(300, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || err !== e[MSGLEN] || msg_out !== e[MSGLEN-1:0]) begin
      errors++;
      $display("FAIL err_clear got err=%b %h required err=%b %h", err, msg_out, e[MSGLEN], e[MSGLEN-1:0]);
    end
  endtask

  task automatic test_start_ignored();
    int n; bit seen; logic [W-1:0] e;
    logic [MSGLEN-1:0] m, x;
    for (int t = 0; t < NSYM; t++) m[4*t +: 4] = 4'(t % 16);
    x = '0;
    for (int t = 1; t < NSYM; t++) x[4*t +: 4] = 4'h1;
    issue(m, '0, 1'b0, x);
    tick(49);
    start  = 1'b1;
    msg_in = {NSYM{4'h7}};
    key    = {16{4'h3}};
    tick(1);
    start = 1'b0;
    wait_done(300, n, seen);
    e = exp_q.pop_front();
    checks++;
    if (!seen || n != LAT - 50) begin
      errors++;
      $display("FAIL ignore_latency got %0d (seen=%0b) required %0d", n, seen, LAT - 50);
    end
    checks++;
    if (msg_out !== e[MSGLEN-1:0] || err !== e[MSGLEN]) begin
      errors++;
      $display("FAIL ignore_result got %h err=%b required %h err=%b", msg_out, err, e[MSGLEN-1:0], e[MSGLEN]);
    end
  endtask

  task automatic test_reset_mid();
    int n; bit seen;
    start  = 1'b1;
    msg_in = {NSYM{4'h9}};
    key    = '0;
    tick(1);
    start = 1'b0;
    tick(79);
    rstn = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || msg_out !== '0) begin
      errors++;
      $display("FAIL midreset_clear busy=%b done=%b err=%b msgOut=%h required all 0", busy, done, err, msg_out);
    end
    tick(2);
    rstn = 1'b1;
    wait_done(200, n, seen);
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL midreset_nodone got done after %0d cycles required none", n);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit seen; logic [W-1:0] e1, e2;
    logic [MSGLEN-1:0] m, x;
    for (int t = 0; t < NSYM; t++) m[4*t +: 4] = 4'(t % 16);
    x = '0;
    for (int t = 1; t < NSYM; t++) x[4*t +: 4] = 4'h1;
    issue(m, '0, 1'b0, x);
    wait_done(300, n, seen);
    e1 = exp_q.pop_front();
    checks++;
    if (!seen || msg_out !== e1[MSGLEN-1:0]) begin
      errors++;
      $display("FAIL b2b_first got %h (seen=%0b) required %h", msg_out, seen, e1[MSGLEN-1:0]);
    end
    // Still in the done cycle: second request.
    issue('0, '0, 1'b0, '0);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept busy got %b required 1", busy);
    end
    tick(100);
    checks++;
    if (msg_out !== e1[MSGLEN-1:0]) begin
      errors++;
      $display("FAIL b2b_hold got %h required %h", msg_out, e1[MSGLEN-1:0]);
    end
    wait_done(300, n, seen);
    e2 = exp_q.pop_front();
    checks++;
    if (!seen || n != LAT - 100) begin
      errors++;
      $display("FAIL b2b_latency got %0d (seen=%0b) required %0d", n + 100, seen, LAT);
    end
    checks++;
    if (msg_out !== e2[MSGLEN-1:0] || err !== e2[MSGLEN]) begin
      errors++;
      $display("FAIL b2b_second got %h err=%b required %h err=%b", msg_out, err, e2[MSGLEN-1:0], e2[MSGLEN]);
    end
  endtask

  task automatic test_random();
    int n; bit seen; logic [W-1:0] e;
    logic [MSGLEN-1:0] pt;
    logic [63:0] kk;
    for (int it = 0; it < 4; it++) begin
      set_ls_sbox();
      for (int w = 0; w < MSGLEN/32; w++) pt[32*w +: 32] = $urandom;
      kk = {$urandom, $urandom};
      issue(fwd(pt, kk), kk, 1'b0, pt);
      wait_done(300, n, seen);
      e = exp_q.pop_front();
      checks++;
      if (!seen || n != LAT || msg_out !== e[MSGLEN-1:0] || err !== e[MSGLEN]) begin
        errors++;
        $display("FAIL random_%0d got %h err=%b lat=%0d required %h err=0", it, msg_out, err, n, e[MSGLEN-1:0]);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rstn   = 1'b0;
    start  = 1'b0;
    msg_in = '0;
    key    = '0;
    set_ls_add();
    tick(3);
    rstn = 1'b1;
    tick(1);
    test_reset();
    test_zero();
    test_ramp();
    test_key2();
    test_err();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
